// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART receiver slice.
//               Holds the receiver state enum and the default payload width.
//               Optional feature macro: UART_RX_PARITY_EN (adds RX_PARITY).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Default payload width for a frame.
  localparam int unsigned UART_DATA_BITS_DEF = 8;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    RX_PARITY    = 3'd5,
`endif
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_sync2.sv
// ============================================================================
// Module      : uart_sync2
// Description : Two-flop synchronizer for a single asynchronous bit.
//               Both flops reset to 1 so an idle-high line looks idle
//               immediately after reset.
// Ports       : clk  - system clock (rising edge)
//               rst  - synchronous active-high reset
//               d_i  - asynchronous input
//               q_o  - synchronized output (2 cycles of latency)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// ============================================================================
// Module      : uart_receiver
// Description : UART receiver with start-bit validation at mid bit, LSB-first
//               data sampling, stop-bit check and line-break recovery.
//               Optional feature macro: UART_RX_PARITY_EN (even parity bit
//               between data and stop, adds parity_err output).
// Parameters  : CLOCKS_PER_PULSE - system clocks per bit (even, >= 4)
//               DATA_BITS        - payload bits per frame (>= 2)
// Ports       : clk        - system clock (rising edge)
//               rst        - synchronous active-high reset
//               rx         - asynchronous serial input, idle high
//               data_out   - last correctly received word
//               data_valid - one-cycle pulse when data_out updates
//               rx_busy    - high while a frame is in progress
//               frame_err  - one-cycle pulse when the stop bit samples low
//               parity_err - (parity build only) pulses with data_valid on
//                            parity mismatch
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = 16,
  parameter int unsigned DATA_BITS        = UART_DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 rx_busy,
  output logic                 frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int unsigned CNT_W = $clog2(CLOCKS_PER_PULSE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 ferr_q;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q;
  logic                 perr_pend_q;
`endif

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  // Bit-period counter advances 0..CLOCKS_PER_PULSE-1 and wraps.
  assign cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      ferr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q      <= 1'b0;
      perr_pend_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      case (state_q)
        RX_IDLE: begin
          if (!rx_s) begin
            state_q <= RX_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        // Re-check the line at the middle of the start bit; a high level
        // there means the falling edge was a glitch.
        RX_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            idx_q <= '0;
            if (!rx_s) begin
              state_q <= RX_DATA;
            end else begin
              state_q <= RX_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        // Sampling one full bit period after mid-start lands mid-bit.
        RX_DATA: begin
          cnt_q <= cnt_d;
          if (cnt_q == CNT_LAST) begin
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            idx_q   <= idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_q <= RX_PARITY;
`else
              state_q <= RX_STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        // Even parity: data bits XOR parity bit must be zero.
        RX_PARITY: begin
          cnt_q <= cnt_d;
          if (cnt_q == CNT_LAST) begin
            perr_pend_q <= ^{shift_q, rx_s};
            state_q     <= RX_STOP;
          end
        end
`endif

        // Returning to IDLE at mid-stop leaves half a bit of margin for a
        // back-to-back start edge.
        RX_STOP: begin
          cnt_q <= cnt_d;
          if (cnt_q == CNT_LAST) begin
            if (rx_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_q  <= perr_pend_q;
`endif
              state_q <= RX_IDLE;
              busy_q  <= 1'b0;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= RX_WAIT_IDLE;
            end
          end
        end

        // Hold off until the line is released after a break.
        RX_WAIT_IDLE: begin
          if (rx_s) begin
            state_q <= RX_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= RX_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign rx_busy    = busy_q;
  assign frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

`default_nettype wire

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLOCKS_PER_PULSE, default 16, meaning system clocks per UART bit period; legal values are even and >= 4.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame.
REQ-003 SHALL have port clk  input  1  system clock; all logic uses the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port data_out  output  DATA_BITS  last correctly received byte.
REQ-007 SHALL have port data_valid  output  1  one-cycle pulse when data_out updates.
REQ-008 SHALL have port rx_busy  output  1  high while a frame is in progress.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit samples low.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all decoding uses the synchronized rx_s, which adds 2 cycles of latency.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-012 IDLE: on rx_s==0, SHALL go to START, clear the bit-period counter and set rx_busy=1.
REQ-013 START: at counter==CLOCKS_PER_PULSE/2-1 (mid start bit), SHALL go to DATA if rx_s==0; otherwise it SHALL treat the event as a false start and return to IDLE with no output pulse.
REQ-014 DATA: SHALL sample rx_s every CLOCKS_PER_PULSE cycles, LSB first, into the shift register; after DATA_BITS samples it SHALL go to STOP.
REQ-015 STOP: SHALL sample rx_s CLOCKS_PER_PULSE cycles after the last data sample.
- Sample==1: data_out loads the shift register and data_valid pulses in the next cycle; FSM returns to IDLE.
- Sample==0: frame_err pulses; data_out is unchanged; FSM goes to WAIT_IDLE.
REQ-016 WAIT_IDLE: SHALL stay until rx_s==1, then go to IDLE; this handles line break and never yields data_valid.
REQ-017 The bit counter SHALL be $clog2(CLOCKS_PER_PULSE) bits wide, count 0..CLOCKS_PER_PULSE-1 and wrap to 0.
REQ-018 rx_busy SHALL be high in every state other than IDLE.
REQ-019 A start bit arriving in the cycle after STOP completes SHALL be accepted (back-to-back frames).
REQ-020 data_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-021 rst=1 SHALL force state=IDLE, data_out=0, data_valid=0, frame_err=0, rx_busy=0, counters=0 and synchronizer flops=1, aborting any frame in progress.
REQ-022 A frame in progress during reset SHALL produce no pulse; reception resumes on the first falling edge after rst deasserts.

Configuration
REQ-023 Macro UART_RX_PARITY_EN:
- Defined: an even-parity bit SHALL be sampled between the last data bit and STOP, and an output parity_err (1 bit) SHALL pulse with data_valid when parity mismatches; data_out still updates.
- Undefined: there SHALL be no parity state and no parity_err port, and frames are 8N1.

Structure
REQ-024 Package uart_pkg SHALL hold the rx state enum typedef and the DATA_BITS default constant.
REQ-025 The synchronizer SHALL be a separate sub-module, uart_sync2, with 1-bit in/out, clk and rst, and reset value 1.

Verification (CLOCKS_PER_PULSE=16)
REQ-026 Byte 8'hAC framed 8N1 on rx -> data_valid pulses once about 154 clocks after the start edge, data_out==8'hAC, frame_err=0.
REQ-027 The upstream transmitter's tx looped into rx, sending 8'h00, 8'hFF, 8'h55 back-to-back -> three data_valid pulses with matching data and no gaps lost.
REQ-028 A 5-clock low glitch on idle rx -> no data_valid, no frame_err, rx_busy returns to 0.
REQ-029 Byte 8'h3C with stop bit held low for 40 clocks, then high -> frame_err pulses once, data_out keeps its previous value, and the next valid frame is received.
REQ-030 rst asserted mid-DATA for 1 cycle -> outputs return to reset values, no pulses, and the following frame 8'hA5 is received correctly.
REQ-031 With UART_RX_PARITY_EN defined, 8'h01 sent with parity bit 0 -> data_valid and parity_err pulse together.
